uart_cmd_slave: RTL and testbench

UART_CMD_SLAVE -- requirements
Module: uart_cmd_slave

---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_byte_rx.sv | 89 ++++++++
 rtl/uart_cmd_slave.sv | 143 ++++++++++++++
 tb/tb_uart_cmd_slave.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM encodings, frame constants and parity helper for the uart blocks
package uart_pkg;
  typedef enum logic [3:0] {
    IDLE, WAIT_DATA, WRITE, READ_REQ, READ_WAIT, TX_START, TX_DATA, TX_PAR, TX_STOP
  } state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS} rx_state_t;
  localparam int FRAME_BITS = 8;
  localparam logic PARITY_ODD = 1'b0;
  function automatic logic par_bit(input logic [FRAME_BITS-1:0] d);
    return (^d) ^ PARITY_ODD;
  endfunction
endpackage

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: synchronized uart byte receiver (rx, en in; active, byte_vld, byte_data, byte_err out)
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int BR = 434
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx,
  input  logic                  en,
  output logic                  active,
  output logic                  byte_vld,
  output logic [FRAME_BITS-1:0] byte_data,
  output logic                  byte_err
);
  localparam int CW = BR > 1 ? $clog2(BR) : 1;
  localparam logic [CW-1:0] LAST = CW'(BR - 1);
  localparam logic [CW-1:0] HALF = CW'(BR / 2 - 1);
  logic s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  rx_state_t st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] idx_q, idx_d;
  logic [FRAME_BITS-1:0] sh_q, sh_d;
  logic par_q, par_d, vld_q, vld_d, err_q, err_d;
  always_comb begin
    s1_d = rx;
    s2_d = s1_q;
    s3_d = s2_q;
    st_d = st_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    sh_d = sh_q;
    par_d = par_q;
    vld_d = 1'b0;
    err_d = 1'b0;
    if (!en) begin
      st_d = RX_IDLE;
      cnt_d = '0;
    end else if (st_q == RX_IDLE) begin
      cnt_d = '0;
      idx_d = '0;
      if (s3_q && !s2_q) st_d = RX_START;
    end else if (st_q == RX_START) begin
      cnt_d = cnt_q == HALF ? '0 : cnt_q + 1'b1;
      if (cnt_q == HALF) st_d = s2_q ? RX_IDLE : RX_BITS;
    end else begin
      cnt_d = cnt_q == LAST ? '0 : cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        idx_d = idx_q + 1'b1;
        if (idx_q < 4'(FRAME_BITS)) sh_d = {s2_q, sh_q[FRAME_BITS-1:1]};
        else if (idx_q == 4'(FRAME_BITS)) par_d = s2_q;
        else begin
          st_d = RX_IDLE;
          vld_d = s2_q && (par_q == par_bit(sh_q));
          err_d = !vld_d;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
      st_q <= RX_IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      sh_q <= '0;
      par_q <= 1'b0;
      vld_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
      st_q <= st_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      sh_q <= sh_d;
      par_q <= par_d;
      vld_q <= vld_d;
      err_q <= err_d;
    end
  end
  assign active = st_q != RX_IDLE;
  assign byte_vld = vld_q;
  assign byte_data = sh_q;
  assign byte_err = err_q;
endmodule

// File: rtl/uart_cmd_slave.sv
// uart_cmd_slave: uart command slave (rx/tx serial; reg_addr/wen/wdata/ren/rdata/rvld register port; busy, err status)
module uart_cmd_slave
  import uart_pkg::*;
#(
  parameter int BR = 434,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       tx,
  output logic [6:0] reg_addr,
  output logic       reg_wen,
  output logic [7:0] reg_wdata,
  output logic       reg_ren,
  input  logic [7:0] reg_rdata,
  input  logic       reg_rvld,
  output logic       busy,
  output logic       err
);
  localparam int CW = BR > 1 ? $clog2(BR) : 1;
  localparam logic [CW-1:0] LAST = CW'(BR - 1);
  localparam int LIMIT = TIMEOUT_BITS * BR;
  localparam int TW = $clog2(LIMIT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(LIMIT - 1);
  state_t state_q, state_d;
  logic [6:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [TW-1:0] to_q, to_d;
  logic wen_q, wen_d, ren_q, ren_d, err_q, err_d, tx_q, tx_d;
  logic rx_en, rx_active, byte_vld, byte_err, tx_phase, bit_end;
  logic [7:0] byte_data;
  assign rx_en = state_q inside {IDLE, WAIT_DATA, WRITE};
  uart_byte_rx #(.BR(BR)) u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .en       (rx_en),
    .active   (rx_active),
    .byte_vld (byte_vld),
    .byte_data(byte_data),
    .byte_err (byte_err)
  );
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    idx_d = idx_q;
    wen_d = 1'b0;
    ren_d = 1'b0;
    err_d = 1'b0;
    to_d = '0;
    tx_phase = state_q inside {TX_START, TX_DATA, TX_PAR, TX_STOP};
    bit_end = cnt_q == LAST;
    cnt_d = tx_phase && !bit_end ? cnt_q + 1'b1 : '0;
    case (state_q)
      IDLE: begin
        if (byte_err) err_d = 1'b1;
        else if (byte_vld) begin
          addr_d = byte_data[6:0];
          ren_d = !byte_data[7];
          state_d = byte_data[7] ? WAIT_DATA : READ_REQ;
        end
      end
      WAIT_DATA: begin
        to_d = rx_active ? '0 : to_q + 1'b1;
        if (byte_err) begin
          err_d = 1'b1;
          state_d = IDLE;
        end else if (byte_vld) begin
          wdata_d = byte_data;
          wen_d = 1'b1;
          state_d = WRITE;
        end else if (!rx_active && to_q == TO_LAST) begin
          err_d = 1'b1;
          state_d = IDLE;
        end
      end
      WRITE: state_d = IDLE;
      READ_REQ, READ_WAIT: begin
        to_d = to_q + 1'b1;
        if (reg_rvld) begin
          rdata_d = reg_rdata;
          state_d = TX_START;
        end else if (to_q == TO_LAST) begin
          err_d = 1'b1;
          state_d = IDLE;
        end else state_d = READ_WAIT;
      end
      TX_START: if (bit_end) begin
        idx_d = '0;
        state_d = TX_DATA;
      end
      TX_DATA: if (bit_end) begin
        idx_d = idx_q + 1'b1;
        if (idx_q == 3'(FRAME_BITS - 1)) state_d = TX_PAR;
      end
      TX_PAR: if (bit_end) state_d = TX_STOP;
      TX_STOP: if (bit_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    tx_d = state_d == TX_START ? 1'b0 :
           state_d == TX_DATA  ? rdata_d[idx_d] :
           state_d == TX_PAR   ? par_bit(rdata_d) : 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q <= '0;
      idx_q <= '0;
      to_q <= '0;
      wen_q <= 1'b0;
      ren_q <= 1'b0;
      err_q <= 1'b0;
      tx_q <= 1'b1;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      to_q <= to_d;
      wen_q <= wen_d;
      ren_q <= ren_d;
      err_q <= err_d;
      tx_q <= tx_d;
    end
  end
  assign tx = tx_q;
  assign reg_addr = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_wen = wen_q;
  assign reg_ren = ren_q;
  assign err = err_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_uart_cmd_slave.sv
// tb_uart_cmd_slave: table-driven and scoreboard checks of the uart command slave
module tb_uart_cmd_slave;
  localparam int BR = 240;
  localparam int TOB = 32;
  logic clk = 1'b0, rst_n = 1'b0, rx = 1'b1, reg_rvld = 1'b0;
  logic [7:0] reg_rdata = 8'h00;
  logic tx, reg_wen, reg_ren, busy, err;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  always #5 clk = ~clk;
  uart_cmd_slave #(.BR(BR), .TIMEOUT_BITS(TOB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .tx       (tx),
    .reg_addr (reg_addr),
    .reg_wen  (reg_wen),
    .reg_wdata(reg_wdata),
    .reg_ren  (reg_ren),
    .reg_rdata(reg_rdata),
    .reg_rvld (reg_rvld),
    .busy     (busy),
    .err      (err)
  );
  typedef struct {
    logic [7:0] cmd;
    logic [7:0] dat;
    bit bad;
    int dly;
    int exp_wen;
    int exp_ren;
    int exp_err;
    int exp_tx;
  } vec_t;
  vec_t v[7];
  int n_chk = 0, n_pass = 0;
  int n_wen = 0, n_ren = 0, n_err = 0, n_txf = 0;
  int rsp_dly = 2;
  logic [7:0] rsp_data = 8'h00;
  bit tx_mon_en = 1'b1, tx_busy = 1'b0;
  logic [14:0] wq[$];
  logic [7:0] tq[$];
  logic [14:0] we;
  logic [7:0] te, tb_byte;
  logic tb_start, tb_par, tb_stop;
  int w0, r0, e0, t0, k, lows;
  logic [6:0] a0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
  endtask
  task automatic send_byte(input logic [7:0] b, input bit bad);
    logic [10:0] f;
    f = {1'b1, (^b) ^ bad, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      rx = f[i];
      repeat (BR) @(negedge clk);
    end
  endtask
  task automatic wait_idle(input string name);
    int c;
    c = 0;
    while ((busy || tx_busy) && c < 20 * BR) begin
      @(negedge clk);
      c++;
    end
    chk(name, 32'(busy || tx_busy), 0);
    repeat (BR) @(negedge clk);
  endtask
  task automatic snap();
    w0 = n_wen;
    r0 = n_ren;
    e0 = n_err;
    t0 = n_txf;
    a0 = reg_addr;
  endtask
  initial forever begin
    @(negedge clk);
    if (reg_wen) begin
      n_wen++;
      chk("wen_expected", 32'(wq.size() > 0), 1);
      if (wq.size() > 0) begin
        we = wq.pop_front();
        chk("wen_addr", 32'(reg_addr), 32'(we[14:8]));
        chk("wen_wdata", 32'(reg_wdata), 32'(we[7:0]));
      end
    end
    if (reg_wen || reg_ren) chk("wen_ren_excl", 32'(reg_wen & reg_ren), 0);
    if (reg_ren) n_ren++;
    if (err) n_err++;
  end
  initial forever begin
    @(negedge clk);
    if (reg_ren && rsp_dly >= 0) begin
      repeat (rsp_dly) @(negedge clk);
      reg_rdata = rsp_data;
      reg_rvld = 1'b1;
      @(negedge clk);
      reg_rvld = 1'b0;
      reg_rdata = 8'h00;
    end
  end
  initial forever begin
    @(negedge clk);
    if (tx_mon_en && rst_n && !tx) begin
      tx_busy = 1'b1;
      repeat (BR / 2) @(negedge clk);
      tb_start = tx;
      for (int i = 0; i < 8; i++) begin
        repeat (BR) @(negedge clk);
        tb_byte[i] = tx;
      end
      repeat (BR) @(negedge clk);
      tb_par = tx;
      repeat (BR) @(negedge clk);
      tb_stop = tx;
      n_txf++;
      chk("tx_expected", 32'(tq.size() > 0), 1);
      if (tq.size() > 0) begin
        te = tq.pop_front();
        chk("tx_start", 32'(tb_start), 0);
        chk("tx_data", 32'(tb_byte), 32'(te));
        chk("tx_parity", 32'(tb_par), 32'(^te));
        chk("tx_stop", 32'(tb_stop), 1);
      end
      tx_busy = 1'b0;
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    v[0] = '{8'h85, 8'h3C, 1'b0, 2, 1, 0, 0, 0};
    v[1] = '{8'h12, 8'hA7, 1'b0, 2, 0, 1, 0, 1};
    v[2] = '{8'hFF, 8'h00, 1'b0, 2, 1, 0, 0, 0};
    v[3] = '{8'h80, 8'hFF, 1'b0, 2, 1, 0, 0, 0};
    v[4] = '{8'h7F, 8'h5A, 1'b0, 0, 0, 1, 0, 1};
    v[5] = '{8'h85, 8'h3C, 1'b1, 2, 0, 0, 1, 0};
    v[6] = '{8'h00, 8'h01, 1'b0, 5, 0, 1, 0, 1};
    repeat (5) @(negedge clk);
    chk("rst_tx", 32'(tx), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_wen", 32'(reg_wen), 0);
    chk("rst_ren", 32'(reg_ren), 0);
    chk("rst_addr", 32'(reg_addr), 0);
    chk("rst_wdata", 32'(reg_wdata), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      snap();
      if (v[i].cmd[7]) begin
        if (!v[i].bad) wq.push_back({v[i].cmd[6:0], v[i].dat});
        send_byte(v[i].cmd, v[i].bad);
        if (!v[i].bad) send_byte(v[i].dat, 1'b0);
      end else begin
        rsp_dly = v[i].dly;
        rsp_data = v[i].dat;
        tq.push_back(v[i].dat);
        send_byte(v[i].cmd, v[i].bad);
      end
      wait_idle($sformatf("v%0d_idle", i));
      chk($sformatf("v%0d_wen", i), n_wen - w0, v[i].exp_wen);
      chk($sformatf("v%0d_ren", i), n_ren - r0, v[i].exp_ren);
      chk($sformatf("v%0d_err", i), n_err - e0, v[i].exp_err);
      chk($sformatf("v%0d_txf", i), n_txf - t0, v[i].exp_tx);
      chk($sformatf("v%0d_addr", i), 32'(reg_addr), v[i].bad ? 32'(a0) : 32'(v[i].cmd[6:0]));
      chk($sformatf("v%0d_tx_idle", i), 32'(tx), 1);
    end
    snap();
    send_byte(8'h85, 1'b0);
    repeat (33 * BR) @(negedge clk);
    chk("wto_err", n_err - e0, 1);
    chk("wto_wen", n_wen - w0, 0);
    chk("wto_busy", 32'(busy), 0);
    snap();
    rsp_dly = 2;
    rsp_data = 8'h3E;
    tq.push_back(8'h3E);
    send_byte(8'h12, 1'b0);
    wait_idle("after_wto_idle");
    chk("after_wto_txf", n_txf - t0, 1);
    chk("after_wto_ren", n_ren - r0, 1);
    chk("after_wto_err", n_err - e0, 0);
    snap();
    rsp_dly = -1;
    send_byte(8'h12, 1'b0);
    repeat ((TOB + 2) * BR) @(negedge clk);
    chk("rto_err", n_err - e0, 1);
    chk("rto_busy", 32'(busy), 0);
    chk("rto_txf", n_txf - t0, 0);
    rsp_dly = 2;
    snap();
    rx = 1'b0;
    repeat (100) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BR) @(negedge clk);
    chk("glitch_err", n_err - e0, 0);
    chk("glitch_busy", 32'(busy), 0);
    chk("glitch_strobes", (n_wen - w0) + (n_ren - r0), 0);
    tx_mon_en = 1'b0;
    rsp_data = 8'hA7;
    send_byte(8'h12, 1'b0);
    k = 0;
    while (tx && k < 10 * BR) begin
      @(negedge clk);
      k++;
    end
    chk("rst_tx_started", 32'(tx), 0);
    repeat (3 * BR) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_tx", 32'(tx), 1);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_addr", 32'(reg_addr), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    lows = 0;
    repeat (12 * BR) begin
      @(negedge clk);
      if (!tx) lows++;
    end
    chk("midrst_no_resume", lows, 0);
    chk("midrst_busy_after", 32'(busy), 0);
    tx_mon_en = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
